// File: rtl/rca_pr_request_queue.sv
// Queue of partial-reconfiguration requests feeding a PR controller, with per-slot busy tracking.
// Optional macro RCA_PR_COALESCE_EN: a new request for an already-queued slot overwrites that entry's OU.
module rca_pr_request_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_SLOTS = 30,
  parameter int unsigned NUM_OUS   = 22,
  parameter int unsigned SLOT_W    = 5,
  parameter int unsigned OU_W      = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  input  logic [SLOT_W-1:0]              req_slot,
  input  logic [OU_W-1:0]                req_ou,
  output logic                           req_ready,
  output logic                           pr_valid,
  output logic [SLOT_W-1:0]              pr_slot,
  output logic [OU_W-1:0]                pr_ou,
  input  logic                           pr_ready,
  input  logic                           pr_done,
  output logic [NUM_SLOTS-1:0]           slot_busy,
  output logic [$clog2(DEPTH+1)-1:0]     queue_count,
  output logic                           req_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SLOT_W-1:0]   r_q_slot [DEPTH];
  logic [OU_W-1:0]     r_q_ou   [DEPTH];
  logic [DEPTH-1:0]    r_q_vld;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_req_ready;
  logic                r_pr_valid;
  logic [SLOT_W-1:0]   r_pr_slot;
  logic [OU_W-1:0]     r_pr_ou;
  logic                r_if_vld;
  logic [SLOT_W-1:0]   r_if_slot;
  logic                r_req_err;

  logic                w_in_range;
  logic                w_accept;
  logic                w_push;
  logic                w_err;
  logic                w_load;
  logic                w_pop;
  logic                w_done;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [NUM_SLOTS-1:0] w_busy;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_in_range = (32'(req_slot) < NUM_SLOTS) && (32'(req_ou) < NUM_OUS);

`ifdef RCA_PR_COALESCE_EN
  logic             w_match;
  logic [PTR_W-1:0] w_match_idx;
  logic             w_coal;

  // The head is only matchable while nothing from it is being presented (WAIT_DONE).
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_q_vld[i] && (r_q_slot[i] == req_slot) &&
          !((PTR_W'(i) == r_rd_ptr) && (r_state != WAIT_DONE))) begin
        w_match     = 1'b1;
        w_match_idx = PTR_W'(i);
      end
    end
  end

  assign w_accept = req_valid && (r_req_ready || (w_in_range && w_match));
  assign w_coal   = w_accept && w_in_range && w_match;
  assign w_push   = w_accept && w_in_range && !w_match;
`else
  assign w_accept = req_valid && r_req_ready;
  assign w_push   = w_accept && w_in_range;
`endif
  assign w_err = w_accept && !w_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = ISSUE;
          w_load      = 1'b1;
        end
      end
      ISSUE: begin
        if (pr_ready) begin
          w_state_nxt = WAIT_DONE;
          w_pop       = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (pr_done) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_q_slot[i] <= '0;
        r_q_ou[i]   <= '0;
      end
      r_q_vld     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b1;
      r_pr_valid  <= 1'b0;
      r_pr_slot   <= '0;
      r_pr_ou     <= '0;
      r_if_vld    <= 1'b0;
      r_if_slot   <= '0;
      r_req_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_q_slot[r_wr_ptr] <= req_slot;
        r_q_ou[r_wr_ptr]   <= req_ou;
        r_q_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr           <= f_inc(r_wr_ptr);
      end
`ifdef RCA_PR_COALESCE_EN
      if (w_coal) r_q_ou[w_match_idx] <= req_ou;
`endif
      if (w_load) begin
        r_pr_valid <= 1'b1;
        r_pr_slot  <= r_q_slot[r_rd_ptr];
        r_pr_ou    <= r_q_ou[r_rd_ptr];
      end
      // Handshake: the presented entry leaves the queue and becomes in-flight.
      if (w_pop) begin
        r_q_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= f_inc(r_rd_ptr);
        r_pr_valid        <= 1'b0;
        r_if_vld          <= 1'b1;
        r_if_slot         <= r_pr_slot;
      end
      if (w_done) r_if_vld <= 1'b0;
      r_count     <= w_count_nxt;
      r_req_ready <= 32'(w_count_nxt) < DEPTH;
      r_req_err   <= w_err;
    end
  end

  // Busy map decoded purely from stored queue entries and the in-flight slot.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_q_vld[i]) w_busy[r_q_slot[i]] = 1'b1;
    end
    if (r_if_vld) w_busy[r_if_slot] = 1'b1;
  end

  assign req_ready   = r_req_ready;
  assign pr_valid    = r_pr_valid;
  assign pr_slot     = r_pr_slot;
  assign pr_ou       = r_pr_ou;
  assign slot_busy   = w_busy;
  assign queue_count = r_count;
  assign req_err     = r_req_err;

endmodule

// File: tb/tb_rca_pr_request_queue.sv
// Bench for rca_pr_request_queue: vector table, directed corner sequences, random run against a queue model.
module tb_rca_pr_request_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [4:0]  req_slot;
  logic [4:0]  req_ou;
  logic        req_ready;
  logic        pr_valid;
  logic [4:0]  pr_slot;
  logic [4:0]  pr_ou;
  logic        pr_ready;
  logic        pr_done;
  logic [29:0] slot_busy;
  logic [3:0]  queue_count;
  logic        req_err;

  rca_pr_request_queue dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_slot(req_slot), .req_ou(req_ou), .req_ready(req_ready),
    .pr_valid(pr_valid), .pr_slot(pr_slot), .pr_ou(pr_ou), .pr_ready(pr_ready),
    .pr_done(pr_done), .slot_busy(slot_busy), .queue_count(queue_count), .req_err(req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] slot;
    logic [4:0] ou;
  } ent_t;

  typedef struct {
    logic        rv;
    logic [4:0]  s;
    logic [4:0]  o;
    logic        prr;
    logic        done;
    logic        e_pv;
    logic [4:0]  e_ps;
    logic [4:0]  e_po;
    logic [3:0]  e_cnt;
    logic [29:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t tbl [13];
  ent_t got [$];
  ent_t exp_q [$];

  // Reference model: request list plus presentation phase (0 idle, 1 presenting, 2 waiting for done).
  ent_t        mq [$];
  int          m_phase;
  ent_t        m_pv;
  logic        m_if_vld;
  logic [4:0]  m_if_slot;
  logic        m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] s, input logic [4:0] o);
    req_valid = 1'b1;
    req_slot  = s;
    req_ou    = o;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; pr_ready = 1'b0; pr_done = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic wait_pv();
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pr_valid) begin ok = 1'b1; break; end
      cyc();
    end
    chk("pv_timeout", 64'(ok), 64'd1);
  endtask

  // Runs the controller side until n requests have been presented, recording them in order.
  task automatic collect(input int n);
    got.delete();
    pr_ready = 1'b1;
    pr_done  = 1'b1;
    for (int k = 0; k < 200 && got.size() < n; k++) begin
      if (pr_valid) got.push_back('{pr_slot, pr_ou});
      cyc();
    end
    cyc();
    pr_ready = 1'b0;
    pr_done  = 1'b0;
    chk("collect_n", 64'(got.size()), 64'(n));
  endtask

  task automatic cmp_got(input string name);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk({name, "_slot"}, 64'(got[i].slot), 64'(exp_q[i].slot));
      chk({name, "_ou"},   64'(got[i].ou),   64'(exp_q[i].ou));
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_if_vld = 1'b0; m_if_slot = '0; m_err = 1'b0; m_pv = '{5'd0, 5'd0};
  endtask

  task automatic check_model();
    logic [29:0] b = '0;
    foreach (mq[i]) b[mq[i].slot] = 1'b1;
    if (m_if_vld) b[m_if_slot] = 1'b1;
    chk("rnd_busy",  64'(slot_busy),   64'(b));
    chk("rnd_count", 64'(queue_count), 64'(mq.size()));
    chk("rnd_ready", 64'(req_ready),   64'(mq.size() < DEPTH));
    chk("rnd_pv",    64'(pr_valid),    64'(m_phase == 1));
    chk("rnd_err",   64'(req_err),     64'(m_err));
    if (m_phase == 1) begin
      chk("rnd_pslot", 64'(pr_slot), 64'(m_pv.slot));
      chk("rnd_pou",   64'(pr_ou),   64'(m_pv.ou));
    end
  endtask

  task automatic model_step();
    bit inr, match, acc, pop;
    int midx;
    inr   = (req_slot < 5'd30) && (req_ou < 5'd22);
    match = 1'b0;
    midx  = 0;
`ifdef RCA_PR_COALESCE_EN
    if (inr)
      for (int i = (m_phase == 2) ? 0 : 1; i < mq.size(); i++)
        if (mq[i].slot == req_slot) begin match = 1'b1; midx = i; end
`endif
    acc = req_valid && ((mq.size() < DEPTH) || match);
    pop = (m_phase == 1) && pr_ready;
    case (m_phase)
      0: if (mq.size() > 0) begin m_phase = 1; m_pv = mq[0]; end
      1: if (pr_ready) begin m_phase = 2; m_if_vld = 1'b1; m_if_slot = m_pv.slot; end
      default: if (pr_done) begin m_phase = 0; m_if_vld = 1'b0; end
    endcase
    if (acc && inr) begin
      if (match) mq[midx].ou = req_ou;
      else       mq.push_back('{req_slot, req_ou});
    end
    if (pop) void'(mq.pop_front());
    m_err = acc && !inr;
  endtask

  localparam logic [29:0] B3  = 30'd1 << 3;
  localparam logic [29:0] B29 = 30'd1 << 29;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_slot = '0; req_ou = '0; pr_ready = 1'b0; pr_done = 1'b0;

    //              rv s  o   prr dn | pv ps  po  cnt busy err
    tbl[0]  = '{1, 3,  7,  1, 0,  0, 0,  0,  1, B3,   0};
    tbl[1]  = '{0, 0,  0,  1, 0,  1, 3,  7,  1, B3,   0};
    tbl[2]  = '{0, 0,  0,  1, 0,  0, 0,  0,  0, B3,   0};
    tbl[3]  = '{0, 0,  0,  1, 0,  0, 0,  0,  0, B3,   0};
    tbl[4]  = '{0, 0,  0,  1, 1,  0, 0,  0,  0, '0,   0};
    tbl[5]  = '{1, 4,  22, 1, 0,  0, 0,  0,  0, '0,   1};
    tbl[6]  = '{0, 0,  0,  1, 0,  0, 0,  0,  0, '0,   0};
    tbl[7]  = '{1, 30, 1,  1, 0,  0, 0,  0,  0, '0,   1};
    tbl[8]  = '{1, 29, 21, 0, 0,  0, 0,  0,  1, B29,  0};
    tbl[9]  = '{0, 0,  0,  0, 0,  1, 29, 21, 1, B29,  0};
    tbl[10] = '{0, 0,  0,  0, 1,  1, 29, 21, 1, B29,  0};
    tbl[11] = '{0, 0,  0,  1, 0,  0, 0,  0,  0, B29,  0};
    tbl[12] = '{0, 0,  0,  1, 1,  0, 0,  0,  0, '0,   0};

    #12;
    chk("rst_pv",    64'(pr_valid),    64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_busy",  64'(slot_busy),   64'd0);
    chk("rst_err",   64'(req_err),     64'd0);
    chk("rst_pslot", 64'({pr_slot, pr_ou}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rst_ready", 64'(req_ready), 64'd1);

    // Single request latency, invalid drops, boundary indices, pr_done ignored in ISSUE.
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].rv; req_slot = tbl[i].s; req_ou = tbl[i].o;
      pr_ready = tbl[i].prr; pr_done = tbl[i].done;
      cyc();
      chk($sformatf("v%0d_pv", i),    64'(pr_valid),    64'(tbl[i].e_pv));
      chk($sformatf("v%0d_count", i), 64'(queue_count), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d_busy", i),  64'(slot_busy),   64'(tbl[i].e_busy));
      chk($sformatf("v%0d_err", i),   64'(req_err),     64'(tbl[i].e_err));
      chk($sformatf("v%0d_ready", i), 64'(req_ready),   64'd1);
      if (tbl[i].e_pv) begin
        chk($sformatf("v%0d_pslot", i), 64'(pr_slot), 64'(tbl[i].e_ps));
        chk($sformatf("v%0d_pou", i),   64'(pr_ou),   64'(tbl[i].e_po));
      end
    end
    req_valid = 1'b0; pr_ready = 1'b0; pr_done = 1'b0;

    // Fill to DEPTH with the controller stalled, then release one slot of space.
    for (int i = 0; i < 8; i++) push(5'(i), 5'(i));
    chk("full_count", 64'(queue_count), 64'd8);
    chk("full_ready", 64'(req_ready),   64'd0);
    chk("full_pslot", 64'(pr_slot),     64'd0);
    req_valid = 1'b1; req_slot = 5'd10; req_ou = 5'd3;
    cyc();
    chk("held_count", 64'(queue_count),  64'd8);
    chk("held_busy",  64'(slot_busy[10]), 64'd0);
    pr_ready = 1'b1;
    cyc();
    chk("pop_count", 64'(queue_count), 64'd7);
    chk("pop_ready", 64'(req_ready),   64'd1);
    pr_ready = 1'b0;
    cyc();
    req_valid = 1'b0;
    chk("ninth_count", 64'(queue_count),   64'd8);
    chk("ninth_busy",  64'(slot_busy[10]), 64'd1);
    collect(8);
    exp_q.delete();
    for (int i = 1; i < 8; i++) exp_q.push_back('{5'(i), 5'(i)});
    exp_q.push_back('{5'd10, 5'd3});
    cmp_got("fifo");
    chk("drain_count", 64'(queue_count), 64'd0);
    chk("drain_busy",  64'(slot_busy),   64'd0);

    // Same-slot requests behind an in-flight one; pr_done together with enqueue to the in-flight slot.
    push(5'd0, 5'd0);
    wait_pv();
    pr_ready = 1'b1; cyc(); pr_ready = 1'b0;
    push(5'd5, 5'd1);
    push(5'd5, 5'd9);
`ifdef RCA_PR_COALESCE_EN
    chk("coal_count", 64'(queue_count), 64'd1);
`else
    chk("coal_count", 64'(queue_count), 64'd2);
`endif
    req_valid = 1'b1; req_slot = 5'd0; req_ou = 5'd2; pr_done = 1'b1;
    cyc();
    req_valid = 1'b0; pr_done = 1'b0;
    chk("done_enq_busy0", 64'(slot_busy[0]), 64'd1);
    chk("done_enq_busy5", 64'(slot_busy[5]), 64'd1);
    exp_q.delete();
`ifdef RCA_PR_COALESCE_EN
    exp_q.push_back('{5'd5, 5'd9});
`else
    exp_q.push_back('{5'd5, 5'd1});
    exp_q.push_back('{5'd5, 5'd9});
`endif
    exp_q.push_back('{5'd0, 5'd2});
    collect(exp_q.size());
    cmp_got("coal");
    chk("coal_busy", 64'(slot_busy), 64'd0);

    // Reset while waiting for done with three queued; later pr_done must not revive anything.
    push(5'd1, 5'd1);
    wait_pv();
    pr_ready = 1'b1; cyc(); pr_ready = 1'b0;
    push(5'd2, 5'd2);
    push(5'd3, 5'd3);
    push(5'd4, 5'd4);
    push(5'd6, 5'd23);
    chk("pre_rst_count", 64'(queue_count), 64'd3);
    chk("pre_rst_err",   64'(req_err),     64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(queue_count), 64'd0);
    chk("mid_rst_busy",  64'(slot_busy),   64'd0);
    chk("mid_rst_err",   64'(req_err),     64'd0);
    chk("mid_rst_pv",    64'(pr_valid),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pr_done = 1'b1; pr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("post_rst_pv",    64'(pr_valid),    64'd0);
      chk("post_rst_count", 64'(queue_count), 64'd0);
      chk("post_rst_ready", 64'(req_ready),   64'd1);
    end

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      check_model();
      req_valid = ($urandom_range(0, 99) < 55);
      req_slot  = 5'($urandom_range(0, 31));
      req_ou    = 5'($urandom_range(0, 23));
      pr_ready  = ($urandom_range(0, 99) < 40);
      pr_done   = ($urandom_range(0, 99) < 30);
      model_step();
      cyc();
    end
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
